// File: rtl/sq_pkg.sv
// Shared types and helpers for the store queue: ROB tag, entry record, age compare, strobe expansion.
package sq_pkg;

    localparam int SQ_ROB_SIZE_LOG = 6;
    localparam int SQ_XLEN         = 64;

    typedef logic [SQ_ROB_SIZE_LOG:0] robidx_t;

    typedef struct packed {
        logic                valid;
        logic                addr_ok;
        logic                mmio;
        logic                committed;
        robidx_t             robidx;
        logic [SQ_XLEN-1:0]  addr;
        logic [SQ_XLEN-1:0]  data;
        logic [7:0]          mask;
    } sq_entry_t;

    // True when tag a is older than tag b; the flag bit flips on every ROB wrap.
    function automatic logic rob_older(input robidx_t a, input robidx_t b);
        return (a[SQ_ROB_SIZE_LOG] ^ b[SQ_ROB_SIZE_LOG]) ^
               (a[SQ_ROB_SIZE_LOG-1:0] < b[SQ_ROB_SIZE_LOG-1:0]);
    endfunction

    function automatic logic [63:0] strobe_to_bitmask(input logic [7:0] strb);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sq_fwd_select.sv
// Combinational youngest-first search for store-to-load forwarding; the caller registers the result.
module sq_fwd_select
    import sq_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  sq_entry_t [DEPTH-1:0] entries,
    input  logic [IDX_W-1:0]      tail_idx,
    input  robidx_t               ld_robidx,
    input  logic [SQ_XLEN-4:0]    ld_dword,
    output logic                  stall,
    output logic                  hit,
    output logic [SQ_XLEN-1:0]    data,
    output logic [7:0]            mask
);

    logic [IDX_W-1:0] slot;
    logic             cand;
    logic             unused_bits;

    // Walk tail-1 down to tail-DEPTH; slots outside the live window are invalid and never match.
    always_comb begin
        stall = 1'b0;
        hit   = 1'b0;
        data  = '0;
        mask  = '0;
        slot  = '0;
        cand  = 1'b0;
        for (int o = 1; o <= DEPTH; o++) begin
            slot = tail_idx - IDX_W'(o);
            cand = entries[slot].valid &
                   (entries[slot].committed | rob_older(entries[slot].robidx, ld_robidx));
            if (cand && !entries[slot].addr_ok) begin
                stall = 1'b1;
            end
            if (cand && entries[slot].addr_ok && !hit &&
                entries[slot].addr[SQ_XLEN-1:3] == ld_dword) begin
                hit  = 1'b1;
                data = entries[slot].data;
                mask = entries[slot].mask;
            end
        end
        if (stall) begin
            hit = 1'b0;
        end
    end

    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_bits = unused_bits ^ entries[i].mmio ^ (^entries[i].addr[2:0]);
        end
    end

endmodule

// File: rtl/sq_fwd_queue.sv
// Store queue with commit/flush, in-order dcache drain and registered load forwarding.
// Optional SQ_PERF_CNT_EN adds saturating performance counters as extra outputs.
module sq_fwd_queue
    import sq_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ROB_SIZE_LOG = SQ_ROB_SIZE_LOG,
    parameter int NUM_COMMIT   = 2,
    parameter int XLEN         = SQ_XLEN
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  enq_valid,
    output logic                                  enq_ready,
    input  logic [ROB_SIZE_LOG:0]                 enq_robidx,
    input  logic                                  wb_valid,
    input  logic                                  wb_mmio,
    input  logic [ROB_SIZE_LOG:0]                 wb_robidx,
    input  logic [XLEN-1:0]                       wb_addr,
    input  logic [XLEN-1:0]                       wb_data,
    input  logic [7:0]                            wb_mask,
    input  logic [NUM_COMMIT-1:0]                 commit_valid,
    input  logic [NUM_COMMIT*(ROB_SIZE_LOG+1)-1:0] commit_robidx,
    input  logic                                  flush_valid,
    input  logic [ROB_SIZE_LOG:0]                 flush_robidx,
    output logic                                  deq_valid,
    input  logic                                  deq_ready,
    output logic [XLEN-1:0]                       deq_addr,
    output logic [XLEN-1:0]                       deq_data,
    output logic [63:0]                           deq_mask,
    input  logic                                  ld_valid,
    input  logic [ROB_SIZE_LOG:0]                 ld_robidx,
    input  logic [XLEN-1:0]                       ld_addr,
    output logic                                  fwd_valid,
    output logic                                  fwd_hit,
    output logic                                  fwd_stall,
    output logic [XLEN-1:0]                       fwd_data,
    output logic [7:0]                            fwd_mask,
`ifdef SQ_PERF_CNT_EN
    output logic [31:0]                           perf_full_cycles,
    output logic [31:0]                           perf_fwd_hits,
    output logic [31:0]                           perf_fwd_stalls,
    output logic [31:0]                           perf_mmio_retired,
`endif
    output logic [$clog2(DEPTH):0]                count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int RW    = ROB_SIZE_LOG + 1;

    sq_entry_t [DEPTH-1:0] entry_reg;
    sq_entry_t             entry_next [DEPTH];
    logic [PTR_W-1:0]      head_reg, head_next, tail_reg, tail_next, flush_tail;
    logic [IDX_W-1:0]      head_idx, tail_idx, slot;
    logic [PTR_W-1:0]      last_off;
    logic                  any_surv;
    logic [DEPTH-1:0]      kill, survive;
    logic                  full, enq_fire, head_rdy, head_mmio, pop;
    logic                  sel_stall, sel_hit;
    logic [SQ_XLEN-1:0]    sel_data;
    logic [7:0]            sel_mask;
    logic                  fwd_valid_reg, fwd_hit_reg, fwd_stall_reg;
    logic [XLEN-1:0]       fwd_data_reg;
    logic [7:0]            fwd_mask_reg;
    logic                  unused_ld_bits;

    assign head_idx  = head_reg[IDX_W-1:0];
    assign tail_idx  = tail_reg[IDX_W-1:0];
    assign full      = (head_idx == tail_idx) && (head_reg[IDX_W] != tail_reg[IDX_W]);
    assign enq_ready = ~full;
    assign enq_fire  = enq_valid & ~full & ~flush_valid;
    assign count     = tail_reg - head_reg;

    // MMIO heads retire silently; only normal stores are offered to the dcache.
    assign head_rdy  = entry_reg[head_idx].valid & entry_reg[head_idx].committed;
    assign head_mmio = entry_reg[head_idx].mmio;
    assign deq_valid = head_rdy & ~head_mmio;
    assign pop       = head_rdy & (head_mmio | deq_ready);
    assign deq_addr  = deq_valid ? entry_reg[head_idx].addr : '0;
    assign deq_data  = deq_valid ? entry_reg[head_idx].data : '0;
    assign deq_mask  = deq_valid ? strobe_to_bitmask(entry_reg[head_idx].mask) : '0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic wb_hit, commit_hit;

            assign wb_hit = wb_valid & entry_reg[gi].valid & (entry_reg[gi].robidx == wb_robidx);
            assign kill[gi] = flush_valid & entry_reg[gi].valid & ~entry_reg[gi].committed &
                              rob_older(flush_robidx, entry_reg[gi].robidx);
            assign survive[gi] = entry_reg[gi].valid & ~kill[gi];

            always_comb begin
                commit_hit = 1'b0;
                for (int p = 0; p < NUM_COMMIT; p++) begin
                    if (commit_valid[p] && commit_robidx[p*RW +: RW] == entry_reg[gi].robidx) begin
                        commit_hit = 1'b1;
                    end
                end
                commit_hit = commit_hit & entry_reg[gi].valid & entry_reg[gi].addr_ok;
            end

            always_comb begin
                entry_next[gi] = entry_reg[gi];
                if (wb_hit) begin
                    entry_next[gi].addr_ok = 1'b1;
                    entry_next[gi].mmio    = wb_mmio;
                    entry_next[gi].addr    = wb_addr;
                    entry_next[gi].data    = wb_data;
                    entry_next[gi].mask    = wb_mask;
                end
                if (commit_hit) begin
                    entry_next[gi].committed = 1'b1;
                end
                if (kill[gi] || (pop && head_idx == IDX_W'(gi))) begin
                    entry_next[gi].valid = 1'b0;
                end
                if (enq_fire && tail_idx == IDX_W'(gi)) begin
                    entry_next[gi]        = '0;
                    entry_next[gi].valid  = 1'b1;
                    entry_next[gi].robidx = enq_robidx;
                end
            end
        end
    endgenerate

    // Survivors of a flush form a prefix from head; tail lands just past the youngest one.
    always_comb begin
        last_off = '0;
        any_surv = 1'b0;
        slot     = '0;
        for (int o = 0; o < DEPTH; o++) begin
            slot = head_idx + IDX_W'(o);
            if (survive[slot]) begin
                any_surv = 1'b1;
                last_off = PTR_W'(o);
            end
        end
        flush_tail = any_surv ? (head_reg + last_off + PTR_W'(1)) : head_reg;
    end

    always_comb begin
        head_next = pop ? head_reg + PTR_W'(1) : head_reg;
        tail_next = tail_reg;
        if (flush_valid) begin
            tail_next = flush_tail;
        end else if (enq_fire) begin
            tail_next = tail_reg + PTR_W'(1);
        end
    end

    sq_fwd_select #(
        .DEPTH (DEPTH)
    ) u_fwd_select (
        .entries   (entry_reg),
        .tail_idx  (tail_idx),
        .ld_robidx (ld_robidx),
        .ld_dword  (ld_addr[XLEN-1:3]),
        .stall     (sel_stall),
        .hit       (sel_hit),
        .data      (sel_data),
        .mask      (sel_mask)
    );

    assign unused_ld_bits = ^ld_addr[2:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            entry_reg     <= '0;
            fwd_valid_reg <= 1'b0;
            fwd_hit_reg   <= 1'b0;
            fwd_stall_reg <= 1'b0;
            fwd_data_reg  <= '0;
            fwd_mask_reg  <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
            fwd_valid_reg <= ld_valid;
            fwd_hit_reg   <= ld_valid & sel_hit;
            fwd_stall_reg <= ld_valid & sel_stall;
            fwd_data_reg  <= (ld_valid & sel_hit) ? sel_data : '0;
            fwd_mask_reg  <= (ld_valid & sel_hit) ? sel_mask : '0;
        end
    end

    assign fwd_valid = fwd_valid_reg;
    assign fwd_hit   = fwd_hit_reg;
    assign fwd_stall = fwd_stall_reg;
    assign fwd_data  = fwd_data_reg;
    assign fwd_mask  = fwd_mask_reg;

`ifdef SQ_PERF_CNT_EN
    logic [31:0] perf_full_reg, perf_hit_reg, perf_stall_reg, perf_mmio_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_full_reg  <= '0;
            perf_hit_reg   <= '0;
            perf_stall_reg <= '0;
            perf_mmio_reg  <= '0;
        end else begin
            if (full && perf_full_reg != '1) perf_full_reg <= perf_full_reg + 32'd1;
            if (ld_valid && sel_hit && perf_hit_reg != '1) perf_hit_reg <= perf_hit_reg + 32'd1;
            if (ld_valid && sel_stall && perf_stall_reg != '1) perf_stall_reg <= perf_stall_reg + 32'd1;
            if (pop && head_mmio && perf_mmio_reg != '1) perf_mmio_reg <= perf_mmio_reg + 32'd1;
        end
    end

    assign perf_full_cycles  = perf_full_reg;
    assign perf_fwd_hits     = perf_hit_reg;
    assign perf_fwd_stalls   = perf_stall_reg;
    assign perf_mmio_retired = perf_mmio_reg;
`endif

endmodule
